// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Sequences the seconds/minutes time counter. In RUN a free-running
//   prescaler produces one sec_inc per second, with a minute carry when the
//   fed-back seconds value is 59. In SET_MIN / SET_SEC the increment button,
//   with auto-repeat, advances the selected field, and disp_en blinks it.
// Ports
//   clk, reset_n      : system clock, asynchronous active-low reset
//   btn_mode, btn_inc : debounced button levels, synchronous to clk
//   sec[5:0]          : current seconds from the time counter (carry source)
//   sec_inc, min_inc  : one-cycle advance pulses
//   mode[1:0]         : 0 RUN, 1 SET_MIN, 2 SET_SEC
//   disp_en           : blink enable for the field being set, 1 in RUN
module time_set_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] sec,
  output logic       sec_inc,
  output logic       min_inc,
  output logic [1:0] mode,
  output logic       disp_en
);

  localparam int PW   = $clog2(TICKS_PER_SEC);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE    = RW'(1);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_SET_MIN = 2'd1;
  localparam logic [1:0] S_SET_SEC = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] presc;
  // rep == 0 means idle; otherwise it counts cycles since the last
  // increment event. rep_phase selects the delay (0) or period (1) target.
  logic [RW-1:0] rep;
  logic          rep_phase;
  logic          mode_prev, inc_prev;
  // Suppresses edges on the first clock after reset so a button held
  // through reset release is not seen as a press.
  logic          armed;

  logic mode_edge, inc_edge, terminal, rep_hit, in_set, inc_event;

  assign mode_edge = armed & btn_mode & ~mode_prev;
  assign inc_edge  = armed & btn_inc  & ~inc_prev;
  assign terminal  = (presc == PRE_LAST);
  assign rep_hit   = (rep != '0) && (rep == (rep_phase ? R_PERIOD : R_DELAY));
  assign in_set    = (state != S_RUN);
  assign inc_event = in_set & btn_inc & (inc_edge | rep_hit);

  always_comb begin
    state_nxt = S_RUN;
    case (state)
      S_RUN:     state_nxt = S_SET_MIN;
      S_SET_MIN: state_nxt = S_SET_SEC;
      default:   state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RUN;
      presc     <= '0;
      rep       <= '0;
      rep_phase <= 1'b0;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
      armed     <= 1'b0;
      sec_inc   <= 1'b0;
      min_inc   <= 1'b0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      armed     <= 1'b1;
      sec_inc   <= 1'b0;
      min_inc   <= 1'b0;
      if (mode_edge) begin
        // Mode change has priority over any tick or increment this cycle.
        state     <= state_nxt;
        presc     <= '0;
        rep       <= '0;
        rep_phase <= 1'b0;
      end else begin
        presc <= terminal ? '0 : presc + PRE_ONE;
        if (!in_set) begin
          rep       <= '0;
          rep_phase <= 1'b0;
          if (terminal) begin
            sec_inc <= 1'b1;
            min_inc <= (sec >= 6'd59);
          end
        end else begin
          if (!btn_inc) begin
            rep       <= '0;
            rep_phase <= 1'b0;
          end else if (inc_edge) begin
            rep       <= R_ONE;
            rep_phase <= 1'b0;
          end else if (rep_hit) begin
            rep       <= R_ONE;
            rep_phase <= 1'b1;
          end else if (rep != '0) begin
            rep <= rep + R_ONE;
          end
          if (inc_event) begin
            if (state == S_SET_MIN) min_inc <= 1'b1;
            else                    sec_inc <= 1'b1;
          end
        end
      end
    end
  end

  assign mode    = state;
  assign disp_en = !in_set || (presc < PRE_HALF);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with TICKS_PER_SEC=10, REPEAT_DELAY=8,
// REPEAT_PERIOD=3. The reference model tracks elapsed cycles since the last
// mode entry and since the first press of a hold, and derives the expected
// outputs from those times arithmetically.
module tb_time_set_ctrl;
  localparam int T = 10;
  localparam int D = 8;
  localparam int P = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0;
  logic [5:0] sec = 6'd5;
  logic sec_inc, min_inc, disp_en;
  logic [1:0] mode;

  time_set_ctrl #(.TICKS_PER_SEC(T), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .sec_inc(sec_inc), .min_inc(min_inc), .mode(mode), .disp_en(disp_en)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  int m_mode, m_since, m_hold;
  logic m_pm, m_pi, m_armed;
  logic e_sec, e_min, e_disp;
  logic [1:0] e_mode;

  task automatic m_reset();
    m_mode = 0; m_since = 0; m_hold = -1;
    m_pm = 1'b0; m_pi = 1'b0; m_armed = 1'b0;
    e_sec = 1'b0; e_min = 1'b0; e_mode = 2'd0; e_disp = 1'b1;
  endtask

  // Drive one clock with the given button levels, then advance the model.
  task automatic step(input logic bm, input logic bi);
    logic me, ie, ev;
    @(negedge clk);
    btn_mode = bm; btn_inc = bi;
    @(posedge clk); #1;
    me = bm & ~m_pm & m_armed;
    ie = bi & ~m_pi & m_armed;
    e_sec = 1'b0; e_min = 1'b0; ev = 1'b0;
    if (me) begin
      m_mode = (m_mode + 1) % 3; m_since = 0; m_hold = -1;
    end else begin
      m_since++;
      if (m_mode == 0) begin
        m_hold = -1;
        if (m_since % T == 0) begin
          e_sec = 1'b1; e_min = (sec >= 6'd59);
        end
      end else begin
        if (!bi) m_hold = -1;
        else if (ie) begin m_hold = 0; ev = 1'b1; end
        else if (m_hold >= 0) begin
          m_hold++;
          ev = (m_hold == D) || (m_hold > D && (m_hold - D) % P == 0);
        end
        if (ev) begin
          if (m_mode == 1) e_min = 1'b1; else e_sec = 1'b1;
        end
      end
    end
    e_mode = 2'(m_mode);
    e_disp = (m_mode == 0) || ((m_since % T) < T / 2);
    m_pm = bm; m_pi = bi; m_armed = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    if ({sec_inc, min_inc, mode, disp_en} !== 5'b00001) begin
      errors++; $display("FAIL reset got=%b exp=00001", {sec_inc, min_inc, mode, disp_en});
    end
    checks++;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_run_cadence();
    int n_sec = 0, n_min = 0, first = -1;
    sec = 6'd5;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b0);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL run_cadence cyc=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
      if (sec_inc) begin n_sec++; if (first < 0) first = i; end
      if (min_inc) n_min++;
    end
    if (n_sec != 3 || n_min != 0 || first != 10) begin
      errors++; $display("FAIL run_count sec=%0d min=%0d first=%0d exp 3 0 10", n_sec, n_min, first);
    end
    checks++;
  endtask

  task automatic test_carry();
    int n_sec = 0, n_min = 0;
    sec = 6'd59;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL carry59 i=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
      if (min_inc !== sec_inc) begin
        errors++; $display("FAIL carry_coincident i=%0d sec_inc=%b min_inc=%b", i, sec_inc, min_inc);
      end
      checks++;
      n_sec += sec_inc; n_min += min_inc;
    end
    if (n_sec != 2 || n_min != 2) begin
      errors++; $display("FAIL carry_count sec=%0d min=%0d exp 2 2", n_sec, n_min);
    end
    checks++;
    sec = 6'd58; n_min = 0; n_sec = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      n_min += min_inc; n_sec += sec_inc;
    end
    if (n_min != 0 || n_sec != 1) begin
      errors++; $display("FAIL carry58 sec=%0d min=%0d exp 1 0", n_sec, n_min);
    end
    checks++;
  endtask

  task automatic test_mode_cycle();
    int hi = 0, lo = 0, n_sec = 0;
    step(1'b1, 1'b0);
    if (mode !== 2'd1 || disp_en !== 1'b1) begin
      errors++; $display("FAIL mode_to_setmin got mode=%0d disp=%b exp 1 1", mode, disp_en);
    end
    checks++;
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL blink i=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
      if (disp_en) hi++; else lo++;
      n_sec += sec_inc;
    end
    // entry cycle was high, so 20 cycles give 10 high / 10 low
    if (hi != 9 || lo != 10 || n_sec != 0) begin
      errors++; $display("FAIL blink_duty hi=%0d lo=%0d sec=%0d exp 9 10 0", hi, lo, n_sec);
    end
    checks++;
    step(1'b1, 1'b0);
    if (mode !== 2'd2) begin
      errors++; $display("FAIL mode_to_setsec got=%0d exp=2", mode);
    end
    checks++;
    repeat (12) begin
      step(1'b0, 1'b0);
      if (sec_inc !== 1'b0) begin
        errors++; $display("FAIL setsec_no_tick got=%b exp=0", sec_inc);
      end
      checks++;
    end
    step(1'b1, 1'b0);
    if (mode !== 2'd0 || disp_en !== 1'b1) begin
      errors++; $display("FAIL mode_to_run got mode=%0d disp=%b exp 0 1", mode, disp_en);
    end
    checks++;
    step(1'b0, 1'b0);
  endtask

  task automatic test_auto_repeat();
    int pulses[$];
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL repeat i=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
      if (min_inc) pulses.push_back(i);
    end
    if (pulses.size() != 5 || pulses[0] != 1 || pulses[1] != 9 || pulses[2] != 12 ||
        pulses[3] != 15 || pulses[4] != 18) begin
      errors++; $display("FAIL repeat_times n=%0d exp pulses at 1 9 12 15 18", pulses.size());
    end
    checks++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (min_inc !== 1'b0 || sec_inc !== 1'b0) begin
        errors++; $display("FAIL release i=%0d got sec=%b min=%b exp 0 0", i, sec_inc, min_inc);
      end
      checks++;
    end
  endtask

  task automatic test_set_sec();
    int n_sec = 0, n_min = 0;
    step(1'b1, 1'b0);
    sec = 6'd59;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, i < 3);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL setsec i=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
      n_sec += sec_inc; n_min += min_inc;
    end
    if (n_sec != 1 || n_min != 0 || mode !== 2'd2) begin
      errors++; $display("FAIL setsec_count sec=%0d min=%0d mode=%0d exp 1 0 2", n_sec, n_min, mode);
    end
    checks++;
  endtask

  task automatic test_collision();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    if (mode !== 2'd2 || min_inc !== 1'b0 || sec_inc !== 1'b0) begin
      errors++; $display("FAIL collision got mode=%0d min=%b sec=%b exp 2 0 0", mode, min_inc, sec_inc);
    end
    checks++;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1);
      if (sec_inc !== 1'b0) begin
        errors++; $display("FAIL collision_hold i=%0d got sec=%b exp 0", i, sec_inc);
      end
      checks++;
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int first = -1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1);
    if (min_inc !== 1'b1 || mode !== 2'd1) begin
      errors++; $display("FAIL pre_reset got min=%b mode=%0d exp 1 1", min_inc, mode);
    end
    checks++;
    #2 reset_n = 1'b0;
    #1;
    if ({sec_inc, min_inc, mode, disp_en} !== 5'b00001) begin
      errors++; $display("FAIL async_reset got=%b exp=00001", {sec_inc, min_inc, mode, disp_en});
    end
    checks++;
    repeat (2) @(posedge clk);
    #1;
    if ({sec_inc, min_inc, mode, disp_en} !== 5'b00001) begin
      errors++; $display("FAIL reset_hold got=%b exp=00001", {sec_inc, min_inc, mode, disp_en});
    end
    checks++;
    reset_n = 1'b1;
    m_reset();
    m_pi = 1'b0;
    sec = 6'd5;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL post_reset i=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
      if (sec_inc && first < 0) first = i;
    end
    if (first != 10) begin
      errors++; $display("FAIL post_reset_first got=%0d exp=10", first);
    end
    checks++;
    step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic bi = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bi = ~bi;
      sec = 6'($urandom_range(50, 63));
      step($urandom_range(0, 24) == 0, bi);
      if ({sec_inc, min_inc, mode, disp_en} !== {e_sec, e_min, e_mode, e_disp}) begin
        errors++; $display("FAIL random i=%0d got=%b exp=%b", i, {sec_inc, min_inc, mode, disp_en}, {e_sec, e_min, e_mode, e_disp});
      end
      checks++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_run_cadence();
    test_carry();
    test_mode_cycle();
    test_auto_repeat();
    test_set_sec();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
